// File: rtl/ip_codma_mem_responder_if.sv
// codma memory bus: request/grant handshake plus 64-bit read and write beat channels.
interface ip_codma_mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  size;
  logic        write_valid;
  logic [63:0] write_data;
  logic        grant;
  logic        read_valid;
  logic [63:0] read_data;
  logic        error;

  modport master (
    output read, write, addr, size, write_valid, write_data,
    input  grant, read_valid, read_data, error
  );

  modport slave (
    input  read, write, addr, size, write_valid, write_data,
    output grant, read_valid, read_data, error
  );
endinterface

// File: rtl/ip_codma_mem_responder.sv
// Memory-side responder for the codma bus: grants after a fixed latency, then streams
// read beats or absorbs write beats from a 64-bit storage array split into two word halves.
module ip_codma_mem_responder #(
  parameter int DEPTH         = 256,
  parameter int GRANT_LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  ip_codma_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_WR, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      beat_q, beat_d;
  logic            op_rd_q, op_rd_d;
  logic            ok_q, ok_d;
  logic [1:0]      size_q, size_d;
  logic            half_q, half_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            grant_q, grant_d;
  logic            error_q, error_d;
  logic            rvalid_q, rvalid_d;
  logic [63:0]     rdata_q, rdata_d;

  logic            req_live;
  logic            decide;
  logic            ok_now;
  logic            wr_en;
  logic [2:0]      nbeats;
  logic [1:0]      last_beat;
  logic [AW-1:0]   mem_idx;
  logic [1:0][31:0] half_rd;

  function automatic logic [2:0] beats_of(input logic [3:0] s);
    case (s)
      4'd2:    return 3'd2;
      4'd3:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic req_ok(input logic [31:0] a, input logic [3:0] s);
    logic [AW:0] idx_ext;
    logic        ok;
    idx_ext = {1'b0, a[AW+2:3]};
    ok = (s <= 4'd3) && (a[1:0] == 2'b00);
    if ((s != 4'd0) && a[2])           ok = 1'b0;
    if ((s == 4'd2) && a[3])           ok = 1'b0;
    if ((s == 4'd3) && (a[4:3] != 0))  ok = 1'b0;
    if ((idx_ext + (AW+1)'(beats_of(s))) > (AW+1)'(DEPTH)) ok = 1'b0;
    if (a[31:AW+3] != 0)               ok = 1'b0;
    return ok;
  endfunction

  // In IDLE the live bus is judged; afterwards the verdict latched at request time is used.
  assign ok_now   = (state_q == S_IDLE) ? req_ok(bus.addr, bus.size) : ok_q;
  assign req_live = (state_q == S_IDLE) ? (bus.read | bus.write)
                                        : (op_rd_q ? bus.read : bus.write);
  assign decide   = req_live &&
                    (((state_q == S_IDLE) && (GRANT_LATENCY == 1)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'(GRANT_LATENCY - 1))));
  assign nbeats    = beats_of({2'b00, size_q});
  assign last_beat = 2'(nbeats - 3'd1);
  assign mem_idx   = idx_q + AW'(beat_q);
  assign wr_en     = (state_q == S_WR) && bus.write_valid && !grant_q && reset_n_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    logic [31:0] mem_q [DEPTH];
    logic        we;
    logic [31:0] wdata;
    assign we    = wr_en && ((size_q != 2'd0) || (half_q == 1'(gi)));
    assign wdata = (size_q == 2'd0) ? bus.write_data[31:0] : bus.write_data[32*gi +: 32];
    always_ff @(posedge clk_i) begin
      if (we) mem_q[mem_idx] <= wdata;
    end
    assign half_rd[gi] = mem_q[mem_idx];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      op_rd_q  <= 1'b0;
      ok_q     <= 1'b0;
      size_q   <= '0;
      half_q   <= 1'b0;
      idx_q    <= '0;
      grant_q  <= 1'b0;
      error_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      op_rd_q  <= op_rd_d;
      ok_q     <= ok_d;
      size_q   <= size_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      error_q  <= error_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    op_rd_d = op_rd_q;
    ok_d    = ok_q;
    size_d  = size_q;
    half_d  = half_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_live) begin
          op_rd_d = bus.read;
          ok_d    = ok_now;
          size_d  = bus.size[1:0];
          half_d  = bus.addr[2];
          idx_d   = bus.addr[AW+2:3];
          cnt_d   = 4'd1;
          beat_d  = 2'd0;
          if (decide) state_d = !ok_now ? S_ERR : (bus.read ? S_RD : S_WR);
          else        state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req_live)   state_d = S_IDLE;
        else if (decide) state_d = !ok_q ? S_ERR : (op_rd_q ? S_RD : S_WR);
        else             cnt_d = cnt_q + 4'd1;
      end
      S_RD: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == last_beat) begin
          state_d = S_IDLE;
          beat_d  = 2'd0;
        end
      end
      S_WR: begin
        if (wr_en) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == last_beat) begin
            state_d = S_IDLE;
            beat_d  = 2'd0;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = decide && ok_now;
    error_d  = decide && !ok_now;
    rvalid_d = (state_q == S_RD);
    rdata_d  = '0;
    if (state_q == S_RD) begin
      if (size_q == 2'd0) rdata_d = {32'h0, half_q ? half_rd[1] : half_rd[0]};
      else                rdata_d = half_rd;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.error      = error_q;
  assign bus.read_valid = rvalid_q;
  assign bus.read_data  = rdata_q;
endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// Bench for ip_codma_mem_responder: directed vectors, corner sequences and random traffic
// checked cycle by cycle against an array model of the storage.
module tb_ip_codma_mem_responder;
  localparam int DEPTH = 256;
  localparam int GL    = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ip_codma_mem_responder_if bus();

  ip_codma_mem_responder #(.DEPTH(DEPTH), .GRANT_LATENCY(GL)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xact   = 0;
  logic [63:0] ref_mem [DEPTH];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  size;
    bit          exp_ok;
  } vec_t;

  vec_t vecs [12];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int beats(input logic [3:0] s);
    case (s)
      4'd2:    return 2;
      4'd3:    return 4;
      default: return 1;
    endcase
  endfunction

  // Legality straight from the rules: alignment by transfer size and in-range entries.
  function automatic bit legal(input logic [31:0] a, input logic [3:0] s);
    longint unsigned last;
    if (s > 4'd3) return 0;
    if (a % 4 != 0) return 0;
    if (s >= 1 && a % 8 != 0) return 0;
    if (s == 2 && a % 16 != 0) return 0;
    if (s == 3 && a % 32 != 0) return 0;
    last = longint'(a >> 3) + longint'(beats(s));
    return last <= DEPTH;
  endfunction

  task automatic idle_bus();
    bus.read        = 1'b0;
    bus.write       = 1'b0;
    bus.addr        = 32'h0;
    bus.size        = 4'd9;
    bus.write_valid = 1'b0;
    bus.write_data  = 64'h0;
  endtask

  task automatic run_xact(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] s,
                          input bit exp_ok, input logic [3:0][63:0] wd,
                          input int gap_at, input int gap_len);
    int          nb;
    int unsigned idx;
    logic [63:0] exp;
    nb  = beats(s);
    idx = a >> 3;
    n_xact++;
    $display("xact %0d: %s addr=%h size=%0d expect %s", n_xact, rd ? "read" : "write",
             a, s, exp_ok ? "grant" : "error");
    bus.read  = rd;
    bus.write = wr;
    bus.addr  = a;
    bus.size  = s;
    for (int k = 0; k <= GL; k++) begin
      @(negedge clk);
      check("grant_timing", 64'(bus.grant), 64'(k == GL && exp_ok));
      check("error_timing", 64'(bus.error), 64'(k == GL && !exp_ok));
      check("rvalid_before_burst", 64'(bus.read_valid), 64'h0);
      @(posedge clk); #1;
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.size  = 4'd9;
    if (!exp_ok) begin
      @(negedge clk);
      check("error_one_cycle", 64'(bus.error), 64'h0);
      check("rvalid_after_error", 64'(bus.read_valid), 64'h0);
      @(posedge clk); #1;
      return;
    end
    if (rd) begin
      for (int b = 0; b < nb; b++) begin
        if (s == 4'd0) exp = a[2] ? {32'h0, ref_mem[idx][63:32]} : {32'h0, ref_mem[idx][31:0]};
        else           exp = ref_mem[idx + b];
        @(negedge clk);
        check("read_valid", 64'(bus.read_valid), 64'h1);
        check("read_data", bus.read_data, exp);
        check("grant_in_burst", 64'(bus.grant), 64'h0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("rvalid_after_burst", 64'(bus.read_valid), 64'h0);
      check("rdata_after_burst", bus.read_data, 64'h0);
      @(posedge clk); #1;
    end else begin
      for (int b = 0; b < nb; b++) begin
        if (b == gap_at) begin
          for (int g = 0; g < gap_len; g++) begin
            bus.write_valid = 1'b0;
            @(negedge clk);
            check("rvalid_write_stall", 64'(bus.read_valid), 64'h0);
            @(posedge clk); #1;
          end
        end
        bus.write_valid = 1'b1;
        bus.write_data  = wd[b];
        @(negedge clk);
        check("rvalid_during_write", 64'(bus.read_valid), 64'h0);
        @(posedge clk); #1;
        if (s == 4'd0) begin
          if (a[2]) ref_mem[idx][63:32] = wd[b][31:0];
          else      ref_mem[idx][31:0]  = wd[b][31:0];
        end else begin
          ref_mem[idx + b] = wd[b];
        end
      end
      bus.write_valid = 1'b0;
      @(negedge clk);
      check("grant_after_write", 64'(bus.grant), 64'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][63:0] wd;
    logic [31:0]      a;
    logic [3:0]       s;
    bit               rd, wr;

    vecs[0]  = '{1, 0, 32'h0000_0008, 4'd2,  0};
    vecs[1]  = '{1, 0, 32'h0000_0000, 4'd7,  0};
    vecs[2]  = '{1, 0, 32'h0000_0800, 4'd3,  0};
    vecs[3]  = '{1, 0, 32'h0000_0042, 4'd0,  0};
    vecs[4]  = '{0, 1, 32'h0000_0044, 4'd1,  0};
    vecs[5]  = '{1, 0, 32'h0000_07F0, 4'd3,  0};
    vecs[6]  = '{1, 0, 32'h0000_07E0, 4'd3,  1};
    vecs[7]  = '{1, 0, 32'h0000_07FC, 4'd0,  1};
    vecs[8]  = '{1, 0, 32'h0000_07F0, 4'd2,  1};
    vecs[9]  = '{1, 1, 32'h0000_0100, 4'd1,  1};
    vecs[10] = '{1, 0, 32'h0000_0000, 4'd9,  0};
    vecs[11] = '{1, 0, 32'h1000_0000, 4'd0,  0};

    idle_bus();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_grant", 64'(bus.grant), 64'h0);
    check("reset_error", 64'(bus.error), 64'h0);
    check("reset_rvalid", 64'(bus.read_valid), 64'h0);
    check("reset_rdata", bus.read_data, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Give every entry a known value so later reads have a defined expectation.
    for (int i = 0; i < DEPTH / 4; i++) begin
      for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom};
      run_xact(0, 1, 32'(i * 32), 4'd3, 1, wd, -1, 0);
    end

    wd[0] = 64'h00000001_00000000;
    wd[1] = 64'h00000003_00000002;
    wd[2] = 64'h00000005_00000004;
    wd[3] = 64'h00000007_00000006;
    run_xact(0, 1, 32'h20, 4'd3, 1, wd, -1, 0);
    run_xact(1, 0, 32'h20, 4'd3, 1, wd, -1, 0);

    wd[0] = 64'hFFFFFFFF_DEADBEEF;
    run_xact(0, 1, 32'h44, 4'd0, 1, wd, -1, 0);
    run_xact(1, 0, 32'h40, 4'd1, 1, wd, -1, 0);
    run_xact(1, 0, 32'h44, 4'd0, 1, wd, -1, 0);

    for (int i = 0; i < 12; i++) begin
      for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom};
      run_xact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].exp_ok, wd, -1, 0);
    end

    for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom};
    run_xact(0, 1, 32'h100, 4'd3, 1, wd, 2, 3);
    run_xact(1, 0, 32'h100, 4'd3, 1, wd, -1, 0);

    $display("xact: read request withdrawn during grant latency");
    bus.read = 1'b1;
    bus.addr = 32'h60;
    bus.size = 4'd1;
    @(posedge clk); #1;
    idle_bus();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drop_no_grant", 64'(bus.grant), 64'h0);
      check("drop_no_error", 64'(bus.error), 64'h0);
      check("drop_no_rvalid", 64'(bus.read_valid), 64'h0);
      @(posedge clk); #1;
    end

    $display("xact: reset asserted during beat 2 of a size-3 read at 0x20");
    bus.read = 1'b1;
    bus.addr = 32'h20;
    bus.size = 4'd3;
    repeat (GL + 1) begin
      @(posedge clk); #1;
    end
    idle_bus();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("beat2_before_reset_valid", 64'(bus.read_valid), 64'h1);
    check("beat2_before_reset_data", bus.read_data, ref_mem[5]);
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_rvalid", 64'(bus.read_valid), 64'h0);
    check("midreset_rdata", bus.read_data, 64'h0);
    check("midreset_grant", 64'(bus.grant), 64'h0);
    check("midreset_error", 64'(bus.error), 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_xact(1, 0, 32'h20, 4'd3, 1, wd, -1, 0);

    for (int t = 0; t < 60; t++) begin
      s = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(4, 15));
      a = 32'($urandom_range(0, DEPTH - 1)) << 3;
      if (s == 4'd2) a = a & ~32'hF;
      if (s == 4'd3) a = a & ~32'h1F;
      if (s == 4'd0 && $urandom_range(0, 1) == 1) a = a | 32'h4;
      if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(0, 13));
      rd = ($urandom_range(0, 1) == 1);
      wr = !rd || ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom};
      run_xact(rd, wr, a, s, legal(a, s), wd, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ip_codma_mem_responder.md
# ip_codma_mem_responder

Synthesisable memory-side responder for the codma bus: it answers read and write requests issued by the codma master on the memory interface, serving them from an internal 64-bit-wide storage array. It sits at the slave end of `mem_interface_t`, alongside the codma top in system builds and testbenches, and provides a cycle-accurate target for read bursts, write bursts, alignment errors and range errors.

## Interface
Parameters:
- `DEPTH` — default 256 — number of 64-bit storage entries; must be a power of two, ≥ 4.
- `GRANT_LATENCY` — default 2 — cycles from the first cycle a request is seen to the `grant` pulse; legal range 1–15.

Ports:
- `clk_i` — in — 1 — single clock; all logic is on the rising edge.
- `reset_n_i` — in — 1 — reset, synchronous, active-low.
- `read` — in — 1 — master read request; held high until `grant`.
- `write` — in — 1 — master write request; held high until `grant`.
- `addr` — in — 32 — byte address, stable while the request is high.
- `size` — in — 4 — transfer size code; 9 means idle.
- `write_valid` — in — 1 — write beat present on `write_data`.
- `write_data` — in — 64 — write beat; bits [31:0] are the lower word.
- `grant` — out — 1 — one-cycle acceptance pulse.
- `read_valid` — out — 1 — read beat present on `read_data`.
- `read_data` — out — 64 — read beat; bits [31:0] are the lower word.
- `error` — out — 1 — one-cycle rejection pulse.

## Operation
- Size codes:
  - 0: 1 word, 1 beat
  - 1: 2 words, 1 beat
  - 2: 4 words, 2 beats
  - 3: 8 words, 4 beats
  - All other codes are illegal while a request is high.
- Entry index is `addr[log2(DEPTH)+2:3]`.
- Rejection: a request is rejected with `error` and no `grant` when any of the following holds:
  - the size code is illegal;
  - `addr[1:0] != 0`;
  - size ≥ 1 and `addr[2] != 0`;
  - size 2 and `addr[3] != 0`, or size 3 and `addr[4:3] != 0`;
  - `index + beats > DEPTH`;
  - the upper address bits above the array are nonzero.
- State machine:
  - IDLE: `read` has priority over `write` when both are high. Go to WAIT.
  - WAIT: count `GRANT_LATENCY` cycles. If the request drops, go to IDLE with no `grant`. If the request is illegal, go to ERR. Otherwise pulse `grant` and go to RD_BURST or WR_BURST.
  - RD_BURST: drive one beat per cycle, contiguous, with `read_valid`=1. Return to IDLE after the last beat.
  - WR_BURST: on each edge with `write_valid`=1, store `write_data` to `index + beat` and advance the beat. Cycles with `write_valid`=0 stall the burst with no timeout. Return to IDLE after the last beat.
  - ERR: hold `error` high for one cycle, then go to IDLE.
- Size 0 accesses:
  - A read places the selected half (`addr[2]`) on `read_data[31:0]`, with `read_data[63:32]`=0.
  - A write stores `write_data[31:0]` into the selected half only. The other half is unchanged.
- `read` and `write` are ignored outside IDLE and WAIT. A new request is accepted in the cycle after returning to IDLE.
- `size` is not examined when both `read` and `write` are low.
- Storage contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset values: `grant`=0, `read_valid`=0, `read_data`=0, `error`=0, state IDLE, beat count 0.
- Reset asserted mid-burst: all outputs are 0 on the next edge and any remaining beats are abandoned. Entries already written remain.
- All outputs are registered.
- Read request first high in cycle C:
  - `grant` is high in cycle C+`GRANT_LATENCY`.
  - The first `read_valid` beat is in cycle C+`GRANT_LATENCY`+1.
  - The last beat is in cycle C+`GRANT_LATENCY`+beats.
- Write: the first `write_valid` beat may occur at the earliest in cycle C+`GRANT_LATENCY`+1. A stored entry is readable by a request made in the cycle after the write completes.
- `error` is high in cycle C+`GRANT_LATENCY` in place of `grant`. `grant` and `error` are never high together.
- `read_valid` is 0 in every cycle outside RD_BURST. `read_data` is 0 whenever `read_valid`=0.

## Test plan
- Reset, then write size 3 at addr 0x20 with beats {0x1_0,0x3_2,0x5_4,0x7_6} (upper_lower), then read size 3 at 0x20 → `grant` at C+2; read beats 0x00000001_00000000 … 0x00000007_00000006 in cycles C+3..C+6.
- Write size 0 at 0x44 with `write_data`=0xFFFF_FFFF_DEAD_BEEF, then read size 1 at 0x40 → `read_data`[63:32]=0xDEADBEEF and [31:0] unchanged; read size 0 at 0x44 → 0x00000000_DEADBEEF.
- Read size 2 at 0x08 (misaligned) and a request with size 7 → `error` pulse at C+2, no `grant`, `read_valid` stays 0.
- With `DEPTH`=256, read size 3 at 0x7E0 → 4 beats from entries 252–255; read size 3 at 0x800 → `error`.
- Write burst with `write_valid` low for 3 cycles between beats 1 and 2 → all 4 beats stored in order; `read` and `write` high together → read serviced.
- `reset_n_i` low during beat 2 of a read → next cycle all outputs 0; a subsequent request behaves normally.
